// File: rtl/picosoc_busdec.sv
// Memory-bus decoder and response mux for the PicoRV32 native interface.
// Registers the address decode, bounds each access with a timeout and latches the first bus error.
module picosoc_busdec #(
    parameter int unsigned  NUM_SLAVES     = 4,
    parameter logic [255:0] SLAVE_BASE     = {8{32'h0}},
    parameter logic [255:0] SLAVE_MASK     = {8{32'h0}},
    parameter int unsigned  TIMEOUT_CYCLES = 255,
    parameter logic [31:0]  ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m_valid,
    input  logic                       m_instr,
    input  logic [31:0]                m_addr,
    input  logic [31:0]                m_wdata,
    input  logic [3:0]                 m_wstrb,
    output logic                       m_ready,
    output logic [31:0]                m_rdata,
    output logic [NUM_SLAVES-1:0]      s_valid,
    output logic                       s_instr,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wstrb,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata,
    output logic                       err_irq,
    output logic [1:0]                 err_code,
    output logic [31:0]                err_addr,
    input  logic                       err_clear
);

    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0]   s_valid_q, s_valid_d;
    logic                    s_instr_q, s_instr_d;
    logic [31:0]             s_addr_q, s_addr_d;
    logic [31:0]             s_wdata_q, s_wdata_d;
    logic [3:0]              s_wstrb_q, s_wstrb_d;
    logic                    m_ready_q, m_ready_d;
    logic [31:0]             m_rdata_q, m_rdata_d;
    logic                    err_irq_q, err_irq_d;
    logic [1:0]              err_code_q, err_code_d;
    logic [31:0]             err_addr_q, err_addr_d;

    logic                    hit;
    logic [SEL_W-1:0]        hit_idx;
    logic                    sel_ready;
    logic [31:0]             sel_rdata;
    logic                    timeout_hit;
    logic                    err_raise;
    logic [1:0]              err_code_new;
    logic [31:0]             err_addr_new;

    // Priority decode: the lowest-index matching window wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((m_addr & SLAVE_MASK[32*i +: 32]) ==
                         (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32]))) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (m_valid) state_d = hit ? ACTIVE : RESP;
            ACTIVE:  if (sel_ready || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        s_valid_d    = s_valid_q;
        s_instr_d    = s_instr_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_wstrb_d    = s_wstrb_q;
        m_ready_d    = 1'b0;
        m_rdata_d    = m_rdata_q;
        err_raise    = 1'b0;
        err_code_new = 2'b00;
        err_addr_new = s_addr_q;
        case (state_q)
            IDLE: begin
                if (m_valid) begin
                    s_instr_d = m_instr;
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    s_wstrb_d = m_wstrb;
                    if (hit) begin
                        sel_d = hit_idx;
                        cnt_d = '0;
                        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                            s_valid_d[i] = (hit_idx == SEL_W'(i));
                        end
                    end else begin
                        m_ready_d    = 1'b1;
                        m_rdata_d    = ERR_RDATA;
                        err_raise    = 1'b1;
                        err_code_new = 2'b01;
                        err_addr_new = m_addr;
                    end
                end
            end
            ACTIVE: begin
                if (sel_ready) begin
                    s_valid_d = '0;
                    m_ready_d = 1'b1;
                    m_rdata_d = sel_rdata;
                end else if (timeout_hit) begin
                    s_valid_d    = '0;
                    m_ready_d    = 1'b1;
                    m_rdata_d    = ERR_RDATA;
                    err_raise    = 1'b1;
                    err_code_new = 2'b10;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        // A new error outranks a simultaneous clear; otherwise the first error is kept.
        err_irq_d  = err_irq_q;
        err_code_d = err_code_q;
        err_addr_d = err_addr_q;
        if (err_raise && (!err_irq_q || err_clear)) begin
            err_irq_d  = 1'b1;
            err_code_d = err_code_new;
            err_addr_d = err_addr_new;
        end else if (err_clear) begin
            err_irq_d  = 1'b0;
            err_code_d = '0;
            err_addr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            s_valid_q  <= '0;
            s_instr_q  <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wstrb_q  <= '0;
            m_ready_q  <= 1'b0;
            m_rdata_q  <= '0;
            err_irq_q  <= 1'b0;
            err_code_q <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            s_valid_q  <= s_valid_d;
            s_instr_q  <= s_instr_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_wstrb_q  <= s_wstrb_d;
            m_ready_q  <= m_ready_d;
            m_rdata_q  <= m_rdata_d;
            err_irq_q  <= err_irq_d;
            err_code_q <= err_code_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign m_ready  = m_ready_q;
    assign m_rdata  = m_rdata_q;
    assign s_valid  = s_valid_q;
    assign s_instr  = s_instr_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wstrb  = s_wstrb_q;
    assign err_irq  = err_irq_q;
    assign err_code = err_code_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_picosoc_busdec.sv
// Bench for picosoc_busdec: randomized master traffic against a window-table reference model,
// with a queue-based scoreboard, plus a reset-abort case and an overlapping-window instance.
module tb_picosoc_busdec;

    localparam int unsigned NS  = 4;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          m_valid = 1'b0, m_instr = 1'b0;
    logic [31:0]   m_addr = '0, m_wdata = '0;
    logic [3:0]    m_wstrb = '0;
    logic          m_ready;
    logic [31:0]   m_rdata;
    logic [NS-1:0] s_valid;
    logic          s_instr;
    logic [31:0]   s_addr, s_wdata;
    logic [3:0]    s_wstrb;
    logic [NS-1:0] s_ready = '0;
    logic [127:0]  s_rdata = '0;
    logic          err_irq;
    logic [1:0]    err_code;
    logic [31:0]   err_addr;
    logic          err_clear = 1'b0;

    picosoc_busdec #(
        .NUM_SLAVES(NS),
        .SLAVE_BASE({128'h0, 32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000}),
        .SLAVE_MASK({128'h0, 32'hFF00_0000, 32'hFFFF_FFF0, 32'hFF00_0000, 32'hFFFF_F000}),
        .TIMEOUT_CYCLES(TO),
        .ERR_RDATA(ERR)
    ) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .err_irq(err_irq), .err_code(err_code), .err_addr(err_addr), .err_clear(err_clear)
    );

    // Second instance: two windows that both match every address.
    logic          ov_m_valid = 1'b0;
    logic [31:0]   ov_m_addr = '0;
    logic          ov_m_ready;
    logic [31:0]   ov_m_rdata;
    logic [1:0]    ov_s_valid;
    logic          ov_s_instr;
    logic [31:0]   ov_s_addr, ov_s_wdata;
    logic [3:0]    ov_s_wstrb;
    logic [1:0]    ov_s_ready = 2'b11;
    logic [63:0]   ov_s_rdata = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
    logic          ov_err_irq;
    logic [1:0]    ov_err_code;
    logic [31:0]   ov_err_addr;

    picosoc_busdec #(
        .NUM_SLAVES(2),
        .SLAVE_BASE({8{32'h0}}),
        .SLAVE_MASK({8{32'h0}}),
        .TIMEOUT_CYCLES(TO),
        .ERR_RDATA(ERR)
    ) dut_ov (
        .clk(clk), .reset(reset),
        .m_valid(ov_m_valid), .m_instr(1'b0), .m_addr(ov_m_addr), .m_wdata(32'h0),
        .m_wstrb(4'h0), .m_ready(ov_m_ready), .m_rdata(ov_m_rdata),
        .s_valid(ov_s_valid), .s_instr(ov_s_instr), .s_addr(ov_s_addr), .s_wdata(ov_s_wdata),
        .s_wstrb(ov_s_wstrb), .s_ready(ov_s_ready), .s_rdata(ov_s_rdata),
        .err_irq(ov_err_irq), .err_code(ov_err_code), .err_addr(ov_err_addr), .err_clear(1'b0)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference model: window table and sticky first-error register.
    logic [31:0] win_base [NS] = '{32'h0000_0000, 32'h0100_0000, 32'h0200_0000, 32'h0300_0000};
    logic [31:0] win_mask [NS] = '{32'hFFFF_F000, 32'hFF00_0000, 32'hFFFF_FFF0, 32'hFF00_0000};
    logic        mdl_irq = 1'b0;
    logic [1:0]  mdl_code = '0;
    logic [31:0] mdl_addr = '0;

    function automatic int ref_target(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & win_mask[i]) == (win_base[i] & win_mask[i])) return i;
        end
        return -1;
    endfunction

    function automatic logic [NS-1:0] onehot(input int t);
        logic [NS-1:0] v;
        v = '0;
        if (t >= 0) v[t] = 1'b1;
        return v;
    endfunction

    typedef struct {
        int          tgt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        logic [31:0] rdata;
        int          issue;
        int          lat;
        int          sv;
        logic        irq;
        logic [1:0]  code;
        logic [31:0] eaddr;
    } exp_t;

    exp_t q[$];

    // Slave behaviour: the addressed slave answers after sl_lat cycles of s_valid;
    // every other ready bit and data slot carries noise.
    int          sl_tgt = -1;
    int          sl_lat = 1000;
    logic [31:0] sl_data = '0;
    int          scnt = 0;

    always @(negedge clk) begin
        logic [NS-1:0] rdy;
        logic [127:0]  rd;
        rdy = NS'($urandom);
        rd  = {$urandom, $urandom, $urandom, $urandom};
        if (sl_tgt >= 0) begin
            if (s_valid[sl_tgt]) scnt++;
            else scnt = 0;
            if (s_valid[sl_tgt]) rdy[sl_tgt] = (scnt == sl_lat);
            rd[32*sl_tgt +: 32] = sl_data;
        end
        s_ready = rdy;
        s_rdata = rd;
    end

    int sv_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset || q.size() == 0) sv_cnt = 0;
        if (!reset) begin
            if (q.size() > 0 && s_valid != '0) begin
                e = q[0];
                sv_cnt++;
                chk("slave_side", 128'({s_valid, s_instr, s_wstrb, s_addr, s_wdata}),
                    128'({onehot(e.tgt), e.instr, e.wstrb, e.addr, e.wdata}));
            end
            if (m_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_m_ready", 128'(m_ready), 128'(0));
                end else begin
                    e = q.pop_front();
                    chk("m_rdata", 128'(m_rdata), 128'(e.rdata));
                    chk("latency", 128'(cyc - e.issue), 128'(e.lat));
                    chk("s_valid_cycles", 128'(sv_cnt), 128'(e.sv));
                    chk("s_valid_dropped", 128'(s_valid), 128'(0));
                    chk("err_state", 128'({err_irq, err_code, err_addr}),
                        128'({e.irq, e.code, e.eaddr}));
                    sv_cnt = 0;
                end
            end
        end
    end

    // lat: cycle of s_valid at which the slave answers; 0 means never.
    // clr_at: cycle (relative to the request) at which err_clear pulses; -1 for none.
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input logic ins, input int lat, input logic [31:0] data, input int clr_at);
        exp_t e;
        int   t;
        bit   err;
        bit   done;
        logic [1:0] code;
        @(negedge clk);
        t       = ref_target(a);
        e.tgt   = t;
        e.addr  = a;
        e.wdata = wd;
        e.wstrb = ws;
        e.instr = ins;
        e.issue = cyc;
        err     = 1'b0;
        code    = 2'b00;
        if (t < 0) begin
            e.rdata = ERR; e.lat = 1; e.sv = 0; err = 1'b1; code = 2'b01;
        end else if (lat >= 1 && lat <= TO) begin
            e.rdata = data; e.lat = lat + 1; e.sv = lat;
        end else begin
            e.rdata = ERR; e.lat = TO + 1; e.sv = TO; err = 1'b1; code = 2'b10;
        end
        if (clr_at >= 0) begin
            mdl_irq = 1'b0; mdl_code = '0; mdl_addr = '0;
        end
        if (err && !mdl_irq) begin
            mdl_irq = 1'b1; mdl_code = code; mdl_addr = a;
        end
        e.irq   = mdl_irq;
        e.code  = mdl_code;
        e.eaddr = mdl_addr;
        q.push_back(e);

        sl_tgt    = t;
        sl_lat    = (lat >= 1) ? lat : 1000;
        sl_data   = data;
        m_valid   = 1'b1;
        m_addr    = a;
        m_wdata   = wd;
        m_wstrb   = ws;
        m_instr   = ins;
        err_clear = (clr_at == 0);
        done      = 1'b0;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(negedge clk);
            if (m_ready) done = 1'b1;
            else err_clear = (n == clr_at);
        end
        m_valid   = 1'b0;
        err_clear = 1'b0;
        chk("response_arrived", 128'(done), 128'(1));
        if (!done) q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          sel;

        repeat (3) @(negedge clk);
        chk("rst_ctrl", 128'({s_valid, m_ready, m_rdata, s_instr, s_wstrb}), 128'(0));
        chk("rst_addr_data", 128'({s_addr, s_wdata}), 128'(0));
        chk("rst_err", 128'({err_irq, err_code, err_addr}), 128'(0));
        chk("rst_ov", 128'({ov_s_valid, ov_m_ready, ov_err_irq}), 128'(0));
        reset = 1'b0;

        issue(32'h0100_0040, 32'h0, 4'h0, 1'b0, 3, 32'h1234_5678, -1);
        issue(32'h0200_0004, 32'hAABB_CCDD, 4'b0011, 1'b0, 2, 32'h5555_0002, -1);
        issue(32'h0500_0000, 32'h0, 4'h0, 1'b0, 1, 32'h0, -1);
        issue(32'h0300_0010, 32'h0, 4'h0, 1'b1, 0, 32'h0, -1);
        issue(32'h0312_3450, 32'h0, 4'h0, 1'b0, 0, 32'h0, TO);
        issue(32'h0300_0100, 32'h0, 4'h0, 1'b0, TO, 32'h3333_0008, -1);
        issue(32'h0200_0010, 32'h0, 4'hF, 1'b0, 1, 32'h0, -1);
        issue(32'h0000_0FFC, 32'h0, 4'h0, 1'b1, 1, 32'h0BAD_F00D, 0);

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0:       a = {20'h00000, 12'($urandom)};
                1:       a = 32'h0100_0000 | {8'h0, 24'($urandom)};
                2:       a = 32'h0200_0000 | {20'h0, 12'($urandom_range(0, 31))};
                3:       a = 32'h0300_0000 | {8'h0, 24'($urandom)};
                default: a = $urandom;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom),
                  int'($urandom_range(1, 10)), $urandom,
                  ($urandom_range(0, 5) == 0) ? 0 : -1);
        end

        // Make sure an error is latched, then reset in the middle of an access.
        issue(32'h0700_0000, 32'h0, 4'h0, 1'b0, 1, 32'h0, -1);
        @(negedge clk);
        sl_tgt  = 3;
        sl_lat  = 1000;
        m_addr  = 32'h0300_0040;
        m_wstrb = 4'h0;
        m_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_abort_active", 128'(s_valid), 128'(4'b1000));
        chk("pre_abort_err", 128'(err_irq), 128'(1));
        reset   = 1'b1;
        m_valid = 1'b0;
        @(negedge clk);
        chk("abort_s_valid", 128'(s_valid), 128'(0));
        chk("abort_m_ready", 128'(m_ready), 128'(0));
        chk("abort_err", 128'({err_irq, err_code, err_addr}), 128'(0));
        reset    = 1'b0;
        mdl_irq  = 1'b0;
        mdl_code = '0;
        mdl_addr = '0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_m_ready", 128'({m_ready, s_valid}), 128'(0));
        end
        issue(32'h0100_1000, 32'h0, 4'h0, 1'b0, 1, 32'hC0DE_0001, -1);

        // Overlapping windows: slave 0 must always win.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ov_m_addr  = $urandom;
            ov_m_valid = 1'b1;
            @(negedge clk);
            chk("ov_s_valid", 128'(ov_s_valid), 128'(2'b01));
            @(negedge clk);
            chk("ov_m_ready", 128'(ov_m_ready), 128'(1));
            chk("ov_m_rdata", 128'(ov_m_rdata), 128'(32'hA0A0_A0A0));
            ov_m_valid = 1'b0;
        end
        chk("ov_no_error", 128'(ov_err_irq), 128'(0));

        repeat (3) @(negedge clk);
        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
